// File: rtl/scoreboard_ctrl.sv
// Register scoreboard for an in-order pipeline: per-register outstanding-write
// counters, RAW/overflow hazard stall, and a drain handshake for register dumps.
module scoreboard_ctrl #(
    parameter int MAX_INFLIGHT = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rs,
    input  logic [4:0]  issue_rt,
    input  logic        issue_rs_used,
    input  logic        issue_rt_used,
    input  logic [4:0]  issue_rd,
    input  logic        issue_we,
    input  logic        retire_valid,
    input  logic [4:0]  retire_rd,
    input  logic        drain_req,
    output logic        stall,
    output logic        issue_fire,
    output logic        drain_done,
    output logic [31:0] busy_mask,
    output logic [6:0]  pending_count,
    output logic [15:0] stall_cycles,
    output logic        sb_error
);

    localparam int CW = (MAX_INFLIGHT < 2) ? 1 : $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r      [32];
    logic [CW-1:0] cnt_next_s [32];
    logic [31:0]   busy_next_s;
    logic [6:0]    pending_next_s;
    logic          hazard_s;
    logic          inc_s;
    logic          ret_s;
    logic          same_s;
    logic          dec_s;
    logic          err_s;

    // Hazard detection and issue handshake from the registered counters
    always_comb begin
        hazard_s   = 1'b0;
        stall      = 1'b0;
        issue_fire = 1'b0;
        if (issue_rs_used && (cnt_r[issue_rs] != '0)) begin
            hazard_s = 1'b1;
        end else if (issue_rt_used && (cnt_r[issue_rt] != '0)) begin
            hazard_s = 1'b1;
        end else if (issue_we && (cnt_r[issue_rd] == CNT_MAX)) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
        if (issue_valid) begin
            stall      = hazard_s || (state_r != ST_RUN);
            issue_fire = !stall;
        end else begin
            stall      = 1'b0;
            issue_fire = 1'b0;
        end
    end

    // Classify this cycle's counter events; a matched issue/retire pair cancels out
    always_comb begin
        inc_s  = issue_fire && issue_we && (issue_rd != 5'd0);
        ret_s  = retire_valid && (retire_rd != 5'd0);
        same_s = inc_s && ret_s && (issue_rd == retire_rd);
        if (same_s) begin
            dec_s = 1'b0;
            err_s = 1'b0;
        end else if (ret_s) begin
            dec_s = (cnt_r[retire_rd] != '0);
            err_s = (cnt_r[retire_rd] == '0);
        end else begin
            dec_s = 1'b0;
            err_s = 1'b0;
        end
    end

    // Next counter values plus the derived busy mask and pending total
    always_comb begin
        cnt_next_s[0]  = '0;
        busy_next_s    = 32'd0;
        pending_next_s = 7'd0;
        for (int i = 1; i < 32; i++) begin
            if (inc_s && !same_s && (issue_rd == 5'(i))) begin
                cnt_next_s[i] = cnt_r[i] + CW'(1);
            end else if (dec_s && (retire_rd == 5'(i))) begin
                cnt_next_s[i] = cnt_r[i] - CW'(1);
            end else begin
                cnt_next_s[i] = cnt_r[i];
            end
            busy_next_s[i] = (cnt_next_s[i] != '0);
            pending_next_s = pending_next_s + 7'(cnt_next_s[i]);
        end
    end

    // Counter state, registered status outputs and sticky error
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                cnt_r[i] <= '0;
            end
            busy_mask     <= 32'd0;
            pending_count <= 7'd0;
            sb_error      <= 1'b0;
            stall_cycles  <= 16'd0;
        end else begin
            cnt_r[0] <= '0;
            for (int i = 1; i < 32; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
            busy_mask     <= busy_next_s;
            pending_count <= pending_next_s;
            if (err_s) begin
                sb_error <= 1'b1;
            end
            if (issue_valid && stall && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end

    // Drain FSM; drain_done is high exactly while in DONE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_RUN;
            drain_done <= 1'b0;
        end else begin
            drain_done <= 1'b0;
            case (state_r)
                ST_RUN: begin
                    if (drain_req) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // A withdrawn request abandons the drain without a pulse
                    if (!drain_req) begin
                        state_r <= ST_RUN;
                    end else if (pending_count == 7'd0) begin
                        state_r    <= ST_DONE;
                        drain_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (drain_req) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

endmodule
